// File: rtl/rocket_stage_sim.sv
// rocket_stage_sim: time-stepped multi-stage rocket velocity integrator.
// Each simulated second the vehicle accelerates by thrust/mass (sequential restoring divider)
// less gravity, burns propellant, and after burnout jettisons the stage's dry mass.
// Units: velocity mm/s, acceleration mm/s^2, masses kg, isp s, burn time s.
module rocket_stage_sim #(
  parameter int IW       = 64,
  parameter int VW       = 128,
  parameter int N_STAGES = 3,
  parameter int GRAVITY  = 9799,
  localparam int SW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_stage,
  input  logic [IW-1:0] cfg_isp,
  input  logic [IW-1:0] cfg_prop,
  input  logic [IW-1:0] cfg_drop,
  input  logic [IW-1:0] cfg_burn,
  input  logic [IW-1:0] initialWeight,
  input  logic [SW:0]   num_stages,
  input  logic          start,
  input  logic          step_en,
  output logic [VW-1:0] velocity,
  output logic [VW-1:0] afterWeight,
  output logic [SW-1:0] stage,
  output logic [31:0]   t_sec,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int TD = 1 << SW;
  localparam int CW = $clog2(VW + 1);
  localparam logic [VW-1:0] G_VW     = VW'(GRAVITY);
  localparam logic [CW-1:0] CNT_LAST = CW'(VW);

  // Control handshakes: start is a one-cycle request honoured only in IDLE/DONE (busy==0),
  // otherwise dropped; step_en is a level permit sampled only while waiting for the next
  // step, and cfg_we writes land only while busy==0.

  typedef enum logic [2:0] {IDLE, S_INIT, S_WAIT, S_DIV, S_UPD, S_SEP, DONE} state_t;
  state_t state_q, state_d;

  logic [IW-1:0] isp_tab  [TD];
  logic [IW-1:0] prop_tab [TD];
  logic [IW-1:0] drop_tab [TD];
  logic [IW-1:0] burn_tab [TD];

  logic [SW:0]   stages_q;
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] k_q, mdot_q, accel_q, mstep_q;
  logic [VW:0]   div_rem;
  logic [VW-1:0] div_quo, div_dsr;

  logic [VW-1:0] cur_isp, cur_prop, cur_drop, cur_burn;
  logic [VW:0]   div_shift, div_rem_nx;
  logic [VW-1:0] div_quo_nx;
  logic [VW-1:0] mstep_sel, div_num, vel_new;
  logic [VW:0]   vel_sum;
  logic          cfg_bad, init_zero, last_tick, last_stage;

  assign cur_isp  = VW'(isp_tab[stage]);
  assign cur_prop = VW'(prop_tab[stage]);
  assign cur_drop = VW'(drop_tab[stage]);
  assign cur_burn = VW'(burn_tab[stage]);

  assign cfg_bad    = (num_stages == '0) || (num_stages > (SW+1)'(N_STAGES));
  assign init_zero  = (cur_burn == '0) || (cur_prop == '0);
  assign last_tick  = (k_q == cur_burn - VW'(1));
  assign last_stage = ((SW+1)'(stage) + (SW+1)'(1)) == stages_q;

  // One restoring-divider iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_shift = {div_rem[VW-1:0], div_quo[VW-1]};
    if (div_shift >= {1'b0, div_dsr}) begin
      div_rem_nx = div_shift - {1'b0, div_dsr};
      div_quo_nx = {div_quo[VW-2:0], 1'b1};
    end else begin
      div_rem_nx = div_shift;
      div_quo_nx = {div_quo[VW-2:0], 1'b0};
    end
  end

  // Propellant burnt this step (last tick takes the truncation remainder) and thrust numerator.
  always_comb begin
    mstep_sel = last_tick ? (cur_prop - mdot_q * (cur_burn - VW'(1))) : mdot_q;
    div_num   = cur_isp * G_VW * mstep_sel;
  end

  // Velocity integration with the vehicle held on the pad while thrust is below gravity.
  always_comb begin
    vel_sum = {1'b0, velocity} + {1'b0, accel_q};
    vel_new = (vel_sum < {1'b0, G_VW}) ? '0 : VW'(vel_sum - {1'b0, G_VW});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = cfg_bad ? DONE : S_INIT;
      S_INIT: begin
        if (cnt_q == '0) begin
          if (init_zero) state_d = S_SEP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (step_en) state_d = S_DIV;
      S_DIV:  if (cnt_q == CNT_LAST) state_d = S_UPD;
      S_UPD:  state_d = last_tick ? S_SEP : S_WAIT;
      S_SEP:  state_d = last_stage ? DONE : S_INIT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: stage table, shared divider, flight state and outputs.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int i = 0; i < TD; i++) begin
        isp_tab[i]  <= '0;
        prop_tab[i] <= '0;
        drop_tab[i] <= '0;
        burn_tab[i] <= '0;
      end
      stages_q    <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      mdot_q      <= '0;
      accel_q     <= '0;
      mstep_q     <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_dsr     <= '0;
      velocity    <= '0;
      afterWeight <= '0;
      stage       <= '0;
      t_sec       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (cfg_we && !busy && (int'(cfg_stage) < N_STAGES)) begin
        isp_tab[cfg_stage]  <= cfg_isp;
        prop_tab[cfg_stage] <= cfg_prop;
        drop_tab[cfg_stage] <= cfg_drop;
        burn_tab[cfg_stage] <= cfg_burn;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // A zero lift-off mass would divide by zero; fly it as 1 kg and flag it.
            afterWeight <= (initialWeight == '0) ? VW'(1) : VW'(initialWeight);
            velocity    <= '0;
            t_sec       <= '0;
            stage       <= '0;
            stages_q    <= num_stages;
            cnt_q       <= '0;
            err         <= cfg_bad || (initialWeight == '0);
            busy        <= !cfg_bad;
            done        <= cfg_bad;
          end
        end
        S_INIT: begin
          if (cnt_q == '0) begin
            if (init_zero) begin
              err <= 1'b1;
            end else begin
              div_quo <= cur_prop;
              div_rem <= '0;
              div_dsr <= cur_burn;
              k_q     <= '0;
              cnt_q   <= cnt_q + CW'(1);
            end
          end else begin
            div_quo <= div_quo_nx;
            div_rem <= div_rem_nx;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) mdot_q <= div_quo_nx;
          end
        end
        S_WAIT: begin
          if (step_en) begin
            mstep_q <= mstep_sel;
            div_quo <= div_num;
            div_rem <= '0;
            div_dsr <= afterWeight;
            cnt_q   <= CW'(1);
          end
        end
        S_DIV: begin
          div_quo <= div_quo_nx;
          div_rem <= div_rem_nx;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) accel_q <= div_quo_nx;
        end
        S_UPD: begin
          velocity <= vel_new;
          if (afterWeight > mstep_q) begin
            afterWeight <= afterWeight - mstep_q;
          end else begin
            afterWeight <= VW'(1);
            err         <= 1'b1;
          end
          t_sec <= t_sec + 32'd1;
          k_q   <= k_q + VW'(1);
        end
        S_SEP: begin
          if (afterWeight > cur_drop) begin
            afterWeight <= afterWeight - cur_drop;
          end else begin
            afterWeight <= VW'(1);
            err         <= 1'b1;
          end
          cnt_q <= '0;
          // The stage index stays on the last flown stage once the flight completes.
          if (last_stage) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            stage <= stage + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rocket_stage_sim.sv
// Bench for rocket_stage_sim: flight-level reference model feeding per-step expected queues,
// one negedge compare process for every simulated second, and directed/random flights.
module tb_rocket_stage_sim;

  localparam int IW = 64;
  localparam int VW = 128;
  localparam int NS = 3;
  localparam int G  = 9799;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_stage = '0;
  logic [IW-1:0] cfg_isp = '0, cfg_prop = '0, cfg_drop = '0, cfg_burn = '0;
  logic [IW-1:0] initialWeight = '0;
  logic [SW:0]   num_stages = '0;
  logic          start = 1'b0;
  logic          step_en = 1'b0;
  logic [VW-1:0] velocity, afterWeight;
  logic [SW-1:0] stage;
  logic [31:0]   t_sec;
  logic          busy, done, err;

  rocket_stage_sim #(.IW(IW), .VW(VW), .N_STAGES(NS), .GRAVITY(G)) dut (
    .clk(clk), .resetb(resetb), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
    .cfg_isp(cfg_isp), .cfg_prop(cfg_prop), .cfg_drop(cfg_drop), .cfg_burn(cfg_burn),
    .initialWeight(initialWeight), .num_stages(num_stages), .start(start), .step_en(step_en),
    .velocity(velocity), .afterWeight(afterWeight), .stage(stage), .t_sec(t_sec),
    .busy(busy), .done(done), .err(err)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected state after each simulated second, plus flight-end expectations.
  logic [VW-1:0] exp_v_q[$];
  logic [VW-1:0] exp_m_q[$];
  logic [SW-1:0] exp_s_q[$];
  logic [VW-1:0] exp_mass_fin;
  int            exp_t_fin;
  logic          exp_err_fin;

  // Bench copy of the stage table.
  logic [IW-1:0] m_isp [NS];
  logic [IW-1:0] m_prop[NS];
  logic [IW-1:0] m_drop[NS];
  logic [IW-1:0] m_burn[NS];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference flight: plain integer arithmetic over stages and seconds.
  task automatic build_model(input logic [VW-1:0] m0, input int ns);
    logic [VW-1:0] mass, vel, mdot, ms, a, sum, isp, prop, drop, burn;
    int t;
    logic e;
    exp_v_q.delete();
    exp_m_q.delete();
    exp_s_q.delete();
    mass = (m0 == 0) ? 1 : m0;
    vel  = 0;
    t    = 0;
    e    = (m0 == 0);
    if (ns < 1 || ns > NS) begin
      e = 1'b1;
    end else begin
      for (int s = 0; s < ns; s++) begin
        isp = m_isp[s]; prop = m_prop[s]; drop = m_drop[s]; burn = m_burn[s];
        if (burn == 0 || prop == 0) begin
          e = 1'b1;
        end else begin
          mdot = prop / burn;
          for (int k = 0; k < int'(burn); k++) begin
            ms  = (k == int'(burn) - 1) ? prop - mdot * (burn - 1) : mdot;
            a   = isp * VW'(G) * ms / mass;
            sum = vel + a;
            vel = (sum < VW'(G)) ? '0 : sum - VW'(G);
            if (mass <= ms) begin mass = 1; e = 1'b1; end
            else mass = mass - ms;
            t++;
            exp_v_q.push_back(vel);
            exp_m_q.push_back(mass);
            exp_s_q.push_back(SW'(s));
          end
        end
        if (mass <= drop) begin mass = 1; e = 1'b1; end
        else mass = mass - drop;
      end
    end
    exp_mass_fin = mass;
    exp_t_fin    = t;
    exp_err_fin  = e;
  endtask

  // Compare process: every new simulated second is checked against the scoreboard.
  logic [31:0]   t_prev = '0;
  int            cyc = 0;
  int            last_step_cyc = 0;
  logic [SW-1:0] last_step_stage = '0;
  logic          have_prev = 1'b0;
  logic          chk_period = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (resetb && t_sec != t_prev && t_sec != 0) begin
      if (exp_v_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL step_extra: unexpected step to t_sec=%0d, expected none", t_sec);
      end else begin
        check("step_velocity", velocity, exp_v_q.pop_front());
        check("step_mass", afterWeight, exp_m_q.pop_front());
        check("step_stage", VW'(stage), VW'(exp_s_q.pop_front()));
        if (chk_period && have_prev && t_sec == t_prev + 1 && stage == last_step_stage)
          check("step_period", VW'(cyc - last_step_cyc), VW'(VW + 2));
      end
      have_prev       = 1'b1;
      last_step_cyc   = cyc;
      last_step_stage = stage;
    end
    if (t_sec == 0) have_prev = 1'b0;
    t_prev = t_sec;
  end

  // Driver: one stage-table write.
  task automatic write_stage(input int s, input logic [IW-1:0] isp, input logic [IW-1:0] prop,
                             input logic [IW-1:0] drop, input logic [IW-1:0] burn);
    @(negedge clk);
    cfg_we = 1'b1; cfg_stage = SW'(s);
    cfg_isp = isp; cfg_prop = prop; cfg_drop = drop; cfg_burn = burn;
    m_isp[s] = isp; m_prop[s] = prop; m_drop[s] = drop; m_burn[s] = burn;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Driver: fly one flight and check its end state.
  task automatic run_flight(input string tag, input logic [IW-1:0] m0, input int ns,
                            input bit pulse, input bit disturb);
    int budget, pulses;
    bit seen;
    build_model(VW'(m0), ns);
    pulses = 0;
    seen   = 0;
    budget = (exp_v_q.size() + 1) * (pulse ? 510 : VW + 12) + (ns + 1) * (VW + 12) + 50;
    chk_period = !pulse;
    @(negedge clk);
    initialWeight = m0; num_stages = (SW+1)'(ns); start = 1'b1; step_en = !pulse;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (done) begin seen = 1; break; end
      if (disturb && c == 300) begin
        start = 1'b1; initialWeight = 7;
        cfg_we = 1'b1; cfg_stage = 0; cfg_isp = 1; cfg_prop = 1; cfg_drop = 1; cfg_burn = 1;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (pulse) begin
        step_en = (c % 500 == 0);
        if (step_en && busy) pulses++;
      end
      @(negedge clk);
    end
    start = 1'b0; cfg_we = 1'b0; step_en = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", tag, budget);
    end
    check({tag, "_done"}, VW'(done), 1);
    check({tag, "_busy"}, VW'(busy), 0);
    check({tag, "_mass"}, afterWeight, exp_mass_fin);
    check({tag, "_t_sec"}, VW'(t_sec), VW'(exp_t_fin));
    check({tag, "_err"}, VW'(err), VW'(exp_err_fin));
    check({tag, "_steps_left"}, VW'(exp_v_q.size()), 0);
    if (pulse) check({tag, "_pulses"}, VW'(pulses), VW'(exp_t_fin));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_velocity"}, velocity, 0);
    check({tag, "_mass"}, afterWeight, 0);
    check({tag, "_stage"}, VW'(stage), 0);
    check({tag, "_t_sec"}, VW'(t_sec), 0);
    check({tag, "_busy"}, VW'(busy), 0);
    check({tag, "_done"}, VW'(done), 0);
    check({tag, "_err"}, VW'(err), 0);
  endtask

  // Main sequence.
  initial begin
    int ns;
    logic [IW-1:0] tot, m0;
    for (int s = 0; s < NS; s++) begin
      m_isp[s] = 0; m_prop[s] = 0; m_drop[s] = 0; m_burn[s] = 0;
    end
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetb = 1'b1;

    // Single stage, with literal pins on the model.
    write_stage(0, 100, 500, 0, 5);
    build_model(1000, 1);
    check("pin_t1_v1", exp_v_q[0], 88191);
    check("pin_t1_m1", exp_m_q[0], 900);
    check("pin_t1_v2", exp_v_q[1], 187269);
    run_flight("t1", 1000, 1, 0, 0);
    check("t1_mass_lit", afterWeight, 500);
    check("t1_t_lit", VW'(t_sec), 5);

    // start and cfg_we while busy must be ignored.
    run_flight("busy_ign", 1000, 1, 0, 1);

    // Remainder on the final tick.
    write_stage(0, 263, 2077000, 0, 168);
    build_model(3233500, 1);
    check("pin_rem_m1", exp_m_q[0], 3233500 - 12363);
    check("pin_rem_last", exp_m_q[166] - exp_m_q[167], 12379);
    run_flight("rem", 3233500, 1, 0, 0);
    check("rem_mass_lit", afterWeight, 1156500);

    // Pad hold.
    write_stage(0, 1, 10, 0, 10);
    build_model(1000, 1);
    check("pin_pad_v", exp_v_q[9], 0);
    run_flight("pad", 1000, 1, 0, 0);
    check("pad_vel", velocity, 0);
    check("pad_mass_lit", afterWeight, 990);

    // Two stages with separation.
    write_stage(0, 100, 500, 200, 5);
    write_stage(1, 300, 100, 0, 2);
    build_model(1000, 2);
    check("pin_2s_m6", exp_m_q[5], 250);
    run_flight("two", 1000, 2, 0, 0);
    check("two_mass_lit", afterWeight, 200);
    check("two_t_lit", VW'(t_sec), 7);

    // Faults.
    write_stage(0, 100, 500, 0, 0);
    run_flight("burn0", 1000, 1, 0, 0);
    check("burn0_err_lit", VW'(err), 1);
    write_stage(0, 100, 500, 600, 5);
    run_flight("drop", 1000, 1, 0, 0);
    check("drop_mass_lit", afterWeight, 1);
    run_flight("ns0", 1000, 0, 0, 0);
    run_flight("ns4", 1000, 4, 0, 0);

    // Real-time gating.
    write_stage(0, 100, 500, 0, 3);
    run_flight("pulse", 1000, 1, 1, 0);

    // Random flights.
    for (int f = 0; f < 4; f++) begin
      ns  = $urandom_range(1, 3);
      tot = 0;
      for (int s = 0; s < ns; s++) begin
        write_stage(s, $urandom_range(1, 400), $urandom_range(1, 3000),
                    $urandom_range(0, 800), $urandom_range(0, 6));
        tot = tot + m_prop[s] + m_drop[s];
      end
      if ($urandom_range(0, 3) == 0) m0 = $urandom_range(1, 3000);
      else m0 = tot + $urandom_range(1, 5000);
      run_flight("rand", m0, ns, 0, 0);
    end

    // Reset in the middle of a step.
    write_stage(0, 100, 500, 0, 5);
    @(negedge clk);
    initialWeight = 1000; num_stages = 1; start = 1'b1; step_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    resetb = 1'b1;
    for (int s = 0; s < NS; s++) begin
      m_isp[s] = 0; m_prop[s] = 0; m_drop[s] = 0; m_burn[s] = 0;
    end
    repeat (300) @(negedge clk);
    check("idle_busy", VW'(busy), 0);
    check("idle_t_sec", VW'(t_sec), 0);
    run_flight("cleared", 1000, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
